// File: rtl/xrv_mult_iter.sv
// Iterative RV32M-style multiplier (MUL/MULH/MULHSU/MULHU) over one DW x DW primitive,
// with a one-entry product cache so a repeated op on identical operands returns in one cycle.
module xrv_mult_iter #(
  parameter int XLEN     = 32,
  parameter int DW       = 16,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      mult_type,
  input  logic            valid,
  output logic            ready,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int N  = XLEN / DW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N * N + 1);
  localparam logic [KW-1:0] LAST_FULL = KW'(N * N - 1);
  localparam logic [KW-1:0] LAST_MUL  = KW'(N * (N + 1) / 2 - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]   a_q, b_q;
  op_t               op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [KW-1:0]     k;
  logic [IW-1:0]     i_idx, j_idx, i_nxt, j_nxt;

  logic [XLEN-1:0]   ca, cb;
  op_t               cop;
  logic [2*XLEN-1:0] cprod;
  logic              cache_vld;
  logic [XLEN-1:0]   result_q;

  op_t               op_in;
  logic              sa_in, sb_in, neg_in, hit, calc_last, pair_wrap;
  logic [XLEN-1:0]   am, bm, hit_res;
  logic [DW-1:0]     a_c, b_c;
  logic [2*DW-1:0]   cp;
  logic [2*XLEN-1:0] pp, prod;
  logic              unused_type_msb;

  assign unused_type_msb = mult_type[2];

  // Request decode and cache lookup
  always_comb begin
    op_in   = op_t'(mult_type[1:0]);
    sa_in   = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    sb_in   = (op_in == OP_MULH);
    neg_in  = (sa_in & a[XLEN-1]) ^ (sb_in & b[XLEN-1]);
    hit     = REUSE_EN && cache_vld && (a == ca) && (b == cb) &&
              ((op_in == cop) || ((op_in == OP_MUL) && (cop != OP_MUL)));
    hit_res = (op_in == OP_MUL) ? cprod[XLEN-1:0] : cprod[2*XLEN-1:XLEN];
  end

  // Magnitudes are derived from the raw registered operands so the cache can hold raw a/b
  always_comb begin
    am = ((op_q == OP_MULH || op_q == OP_MULHSU) && a_q[XLEN-1]) ? -a_q : a_q;
    bm = ((op_q == OP_MULH) && b_q[XLEN-1]) ? -b_q : b_q;
    a_c = am[int'(i_idx)*DW +: DW];
    b_c = bm[int'(j_idx)*DW +: DW];
    cp  = (2*DW)'(a_c) * (2*DW)'(b_c);
    pp  = (2*XLEN)'(cp) << (DW * (int'(i_idx) + int'(j_idx)));
    prod = neg_q ? -acc : acc;
  end

  // MUL only walks pairs with i+j < N; those above cannot reach the low word
  always_comb begin
    pair_wrap = (op_q == OP_MUL) ? (int'(i_idx) + int'(j_idx) + 1 >= N)
                                 : (int'(j_idx) + 1 >= N);
    i_nxt = i_idx;
    j_nxt = j_idx + IW'(1);
    if (pair_wrap) begin
      i_nxt = i_idx + IW'(1);
      j_nxt = '0;
    end
    calc_last = (k == ((op_q == OP_MUL) ? LAST_MUL : LAST_FULL));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: state_nxt = valid ? (hit ? DONE : CALC) : IDLE;
        CALC:       state_nxt = calc_last ? FIX : CALC;
        FIX:        state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready        = (state == IDLE) || (state == DONE);
    result_valid = (state == DONE);
    result       = result_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      acc       <= '0;
      k         <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      ca        <= '0;
      cb        <= '0;
      cop       <= OP_MUL;
      cprod     <= '0;
      cache_vld <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      cache_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_in;
            neg_q <= neg_in;
            if (hit) begin
              result_q <= hit_res;
            end else begin
              acc   <= '0;
              k     <= '0;
              i_idx <= '0;
              j_idx <= '0;
            end
          end
        end
        CALC: begin
          acc   <= acc + pp;
          k     <= k + KW'(1);
          i_idx <= i_nxt;
          j_idx <= j_nxt;
        end
        FIX: begin
          result_q  <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          ca        <= a_q;
          cb        <= b_q;
          cop       <= op_q;
          cprod     <= prod;
          cache_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
